serial_output_tx: RTL and testbench

//  UART transmitter at the far end of the core's serial-output path. Accepts byte writes (serialWE +

---
 rtl/SerialTxTypes.sv | 15 +
 rtl/serial_tx_fifo.sv | 44 ++++
 rtl/serial_output_tx.sv | 107 ++++++++++
 tb/tb_serial_output_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/SerialTxTypes.sv
// SerialTxTypes: shared FSM state, baud counter sizing and FIFO index types for the serial TX path.
package SerialTxTypes;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} SerialTxState;

    // Index types for the default 16-entry FIFO; parameterised instances size their own.
    localparam int DEFAULT_FIFO_DEPTH = 16;
    typedef logic [$clog2(DEFAULT_FIFO_DEPTH)-1:0] TxFifoPtr;
    typedef logic [$clog2(DEFAULT_FIFO_DEPTH):0]   TxFifoCount;

    function automatic int baud_cnt_width(input int cycles_per_bit);
        return $clog2(cycles_per_bit);
    endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: synchronous FIFO; a push while full is accepted when a pop happens in the same cycle.
module serial_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/serial_output_tx.sv
// serial_output_tx: FIFO-buffered UART transmitter, 8N1 by default.
// Defining SERIAL_TX_PARITY_EN inserts an even-parity bit between data and stop (8E1).
module serial_output_tx
    import SerialTxTypes::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic                        serialWE,
    input  logic [DATA_WIDTH-1:0]       serialWriteDataIn,
    output logic                        txOut,
    output logic                        txBusy,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount,
    output logic                        overflow
);
    localparam int CPB = CLOCK_FREQ / BAUD_RATE;
    localparam int BW  = baud_cnt_width(CPB);
    localparam int IW  = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;

    SerialTxState          state, state_d;
    logic [BW-1:0]         cnt, cnt_d;
    logic [IW-1:0]         idx, idx_d;
    logic [DATA_WIDTH-1:0] shift, shift_d, rdata;
    logic                  tx_d, pop, full, empty, bit_done, last_bit;
`ifdef SERIAL_TX_PARITY_EN
    logic                  par;
`endif

    serial_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
        .clk(clk), .rstN(rstN), .push(serialWE), .pop(pop), .wdata(serialWriteDataIn),
        .rdata(rdata), .full(full), .empty(empty), .count(fifoCount)
    );

    assign bit_done = cnt == BW'(CPB - 1);
    assign last_bit = idx == IW'(DATA_WIDTH - 1);
    assign txBusy   = state != IDLE || !empty;

    always_comb begin
        state_d = state;
        cnt_d   = (state == IDLE || bit_done) ? '0 : cnt + 1'b1;
        idx_d   = idx;
        shift_d = shift;
        pop     = 1'b0;
        case (state)
            IDLE:  pop = !empty;
            START: if (bit_done) state_d = DATA;
            DATA:  if (bit_done) begin
                shift_d = shift >> 1;
                idx_d   = last_bit ? '0 : idx + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                if (last_bit) state_d = PARITY;
`else
                if (last_bit) state_d = STOP;
`endif
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (bit_done) state_d = STOP;
`endif
            STOP:  if (bit_done) begin
                pop     = !empty;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A pop from IDLE or at the end of STOP starts the next frame straight away.
        if (pop) begin
            state_d = START;
            shift_d = rdata;
            idx_d   = '0;
        end
        tx_d = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`ifdef SERIAL_TX_PARITY_EN
        if (state == PARITY) tx_d = par;
`endif
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            txOut    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            idx      <= idx_d;
            shift    <= shift_d;
            txOut    <= tx_d;
            overflow <= overflow | (serialWE & full & ~pop);
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Parity is latched at load time because the shift register is consumed bit by bit.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) par <= 1'b0;
        else if (pop) par <= ^rdata;
    end
`endif

endmodule

// File: tb/tb_serial_output_tx.sv
// tb_serial_output_tx: directed checks of serial_output_tx at 16 cycles/bit with a 4-entry FIFO.
module tb_serial_output_tx;
    localparam int CPB = 16;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = (10 + PB) * CPB;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       serialWE = 1'b0;
    logic [7:0] serialWriteDataIn = 8'h00;
    logic       txOut, txBusy, overflow;
    logic [2:0] fifoCount;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;

    serial_output_tx #(.CLOCK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rstN(rstN), .serialWE(serialWE), .serialWriteDataIn(serialWriteDataIn),
        .txOut(txOut), .txBusy(txBusy), .fifoCount(fifoCount), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic write_byte(input logic [7:0] d, output int wcyc);
        @(negedge clk);
        serialWE = 1'b1;
        serialWriteDataIn = d;
        @(negedge clk);
        serialWE = 1'b0;
        wcyc = cyc;
    endtask

    task automatic rx_frame(input int budget, output logic [7:0] b, output logic par,
                            output logic stp, output int fall, output bit ok);
        ok = 1'b0; fall = -1; b = 8'h00; par = 1'b0; stp = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (txOut === 1'b0) begin
                ok = 1'b1;
                fall = cyc;
                break;
            end
        end
        if (!ok) return;
        repeat (8) @(negedge clk);
        if (txOut !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = txOut;
        end
`ifdef SERIAL_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        par = txOut;
`endif
        repeat (CPB) @(negedge clk);
        stp = txOut;
    endtask

    task automatic test_reset();
        int edges = 0;
        logic prev;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (txOut !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", txOut); end
        n_checks++; if (txBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", txBusy); end
        n_checks++; if (fifoCount !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifoCount); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        rstN = 1'b1;
        prev = txOut;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txOut !== prev) edges++;
            prev = txOut;
        end
        n_checks++; if (edges != 0) begin n_fail++; $display("FAIL reset_idle_edges: got %0d want 0", edges); end
        n_checks++; if (txBusy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", txBusy); end
    endtask

    task automatic test_single(input logic [7:0] d, input logic exp_par);
        int w, fall;
        bit ok;
        logic [7:0] b;
        logic par, stp;
        write_byte(d, w);
        n_checks++; if (fifoCount !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", fifoCount); end
        rx_frame(50, b, par, stp, fall, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_frame: got none want frame %h", d); end
        n_checks++; if (fall - w != 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", fall - w); end
        n_checks++; if (b !== d) begin n_fail++; $display("FAIL single_data: got %h want %h", b, d); end
        n_checks++; if (stp !== 1'b1) begin n_fail++; $display("FAIL single_stop: got %b want 1", stp); end
`ifdef SERIAL_TX_PARITY_EN
        n_checks++; if (par !== exp_par) begin n_fail++; $display("FAIL single_parity: got %b want %b", par, exp_par); end
`else
        if (exp_par !== ^d) $display("note: parity argument inconsistent for %h", d);
`endif
        repeat (6) @(negedge clk);
        n_checks++; if (txBusy !== 1'b1) begin n_fail++; $display("FAIL single_busy_end: got %b want 1", txBusy); end
        @(negedge clk);
        n_checks++; if (txBusy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b want 0", txBusy); end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    @(negedge clk);
                    serialWE = 1'b1;
                    serialWriteDataIn = 8'(i);
                end
                @(negedge clk);
                serialWE = 1'b0;
                n_checks++; if (fifoCount !== 3'd4) begin n_fail++; $display("FAIL burst_count: got %0d want 4", fifoCount); end
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL burst_ovf: got %b want 0", overflow); end
            end
            begin
                int fall, prev;
                bit ok;
                logic [7:0] b;
                logic par, stp;
                prev = 0;
                for (int k = 0; k < 5; k++) begin
                    rx_frame(FRAME + 50, b, par, stp, fall, ok);
                    n_checks++; if (!ok || b !== 8'(k + 1)) begin n_fail++; $display("FAIL burst_data%0d: got %h ok=%0d want %h", k, b, ok, k + 1); end
                    n_checks++; if (stp !== 1'b1) begin n_fail++; $display("FAIL burst_stop%0d: got %b want 1", k, stp); end
                    if (k > 0) begin
                        n_checks++; if (fall - prev != FRAME) begin n_fail++; $display("FAIL burst_gap%0d: got %0d want %0d", k, fall - prev, FRAME); end
                    end
                    prev = fall;
                end
            end
        join
        repeat (20) @(negedge clk);
        n_checks++; if (txBusy !== 1'b0) begin n_fail++; $display("FAIL burst_busy: got %b want 0", txBusy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL burst_ovf_end: got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_seq [6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h66};
        int fall;
        bit ok;
        logic [7:0] b;
        logic par, stp;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    serialWE = 1'b1;
                    serialWriteDataIn = 8'h11 + 8'(i);
                end
                @(negedge clk);
                serialWE = 1'b0;
                n_checks++; if (fifoCount !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_fill: got count %0d ovf %b want 4 0", fifoCount, overflow); end
                serialWE = 1'b1;
                serialWriteDataIn = 8'hAA;
                @(negedge clk);
                serialWE = 1'b0;
                n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
                n_checks++; if (fifoCount !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", fifoCount); end
                repeat (FRAME - 5) @(negedge clk);
                serialWE = 1'b1;
                serialWriteDataIn = 8'h66;
                @(negedge clk);
                serialWE = 1'b0;
                n_checks++; if (fifoCount !== 3'd4) begin n_fail++; $display("FAIL ovf_pop_push: got %0d want 4", fifoCount); end
                n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    rx_frame(FRAME + 50, b, par, stp, fall, ok);
                    n_checks++; if (!ok || b !== exp_seq[k]) begin n_fail++; $display("FAIL ovf_data%0d: got %h ok=%0d want %h", k, b, ok, exp_seq[k]); end
                end
            end
        join
        rx_frame(2 * FRAME, b, par, stp, fall, ok);
        n_checks++; if (ok) begin n_fail++; $display("FAIL ovf_dropped: got frame %h want none", b); end
        n_checks++; if (overflow !== 1'b1 || txBusy !== 1'b0) begin n_fail++; $display("FAIL ovf_end: got ovf %b busy %b want 1 0", overflow, txBusy); end
    endtask

    task automatic test_reset_mid_frame();
        int w, fall;
        bit ok;
        logic [7:0] b;
        logic par, stp;
        write_byte(8'hF7, w);
        write_byte(8'h3C, w);
        repeat (72) @(negedge clk);
        n_checks++; if (txOut !== 1'b0 || fifoCount !== 3'd1) begin n_fail++; $display("FAIL mid_bit3: got tx %b count %0d want 0 1", txOut, fifoCount); end
        rstN = 1'b0;
        #1;
        n_checks++; if (txOut !== 1'b1) begin n_fail++; $display("FAIL mid_async_tx: got %b want 1", txOut); end
        n_checks++; if (fifoCount !== 3'd0 || txBusy !== 1'b0) begin n_fail++; $display("FAIL mid_async_state: got count %0d busy %b want 0 0", fifoCount, txBusy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_async_ovf: got %b want 0", overflow); end
        @(negedge clk);
        rstN = 1'b1;
        rx_frame(300, b, par, stp, fall, ok);
        n_checks++; if (ok) begin n_fail++; $display("FAIL mid_nothing_sent: got frame %h want none", b); end
    endtask

    initial begin
        test_reset();
        test_single(8'h55, 1'b0);
`ifdef SERIAL_TX_PARITY_EN
        test_single(8'h07, 1'b1);
        test_single(8'h03, 1'b0);
`endif
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
